// File: rtl/demux4_collect.sv
// ---------------------------------------------------------------------------
// demux4_collect
//
// Four-slot capture and drain stage that sits behind a 4-way demultiplexer.
// A word presented on ch[sel] while in_valid is high is latched into that
// channel's holding slot. Full slots are drained one at a time, round-robin,
// through a single valid/ready port that tags each word with its channel.
//
// Build option:
//   DEMUX4_COLLECT_OVF_EN  defined     -> a capture into a full, non-draining
//                                         slot is dropped and ovf[k] sets
//                                         (sticky until rst).
//                          not defined -> a capture into a full slot
//                                         overwrites it; ovf is constant 0.
//
// Ports:
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   ch[sel] carries a word to capture this cycle
//   sel        channel steered by the demux this cycle
//   ch0..ch3   demux outputs (only ch[sel] is sampled)
//   out_valid  at least one slot is full
//   out_ready  consumer accepts out_data this cycle
//   out_data   contents of the granted slot (0 when out_valid is low)
//   out_chan   index of the granted slot (0 when out_valid is low)
//   ovf        sticky per-channel overflow flags
// ---------------------------------------------------------------------------
module demux4_collect #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [1:0]   sel,
    input  logic [W-1:0] ch0,
    input  logic [W-1:0] ch1,
    input  logic [W-1:0] ch2,
    input  logic [W-1:0] ch3,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic [1:0]   out_chan,
    output logic [3:0]   ovf
);

    logic [W-1:0] slot_q [4];
    logic [W-1:0] slot_d [4];
    logic [3:0]   full_q, full_d;
    logic [1:0]   ptr_q, ptr_d;
`ifdef DEMUX4_COLLECT_OVF_EN
    logic [3:0]   ovf_q, ovf_d;
`endif

    logic [W-1:0] ch_arr [4];
    logic [1:0]   grant;
    logic         drain;

    assign ch_arr[0] = ch0;
    assign ch_arr[1] = ch1;
    assign ch_arr[2] = ch2;
    assign ch_arr[3] = ch3;

    // Grant: first full slot searching ptr, ptr+1, ptr+2, ptr+3 (2-bit wrap).
    always_comb begin
        logic       found;
        logic [1:0] idx;
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        grant = 2'd0;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!found && full_q[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    // Outputs depend on registers only; zeroed while nothing is pending.
    assign out_valid = |full_q;
    assign out_chan  = out_valid ? grant : 2'd0;
    assign out_data  = out_valid ? slot_q[grant] : '0;
    assign drain     = out_valid && out_ready;

`ifdef DEMUX4_COLLECT_OVF_EN
    assign ovf = ovf_q;
`else
    assign ovf = 4'b0000;
`endif

    // Next-state: drain first, then capture. A capture on the slot that is
    // draining this edge refills it, so the slot simply stays full.
    always_comb begin
        slot_d = slot_q;
        full_d = full_q;
        ptr_d  = ptr_q;
`ifdef DEMUX4_COLLECT_OVF_EN
        ovf_d  = ovf_q;
`endif

        if (drain) begin
            full_d[grant] = 1'b0;
            ptr_d         = grant + 2'd1;
        end

        if (in_valid) begin
            if (!full_q[sel] || (drain && grant == sel)) begin
                slot_d[sel] = ch_arr[sel];
                full_d[sel] = 1'b1;
            end else begin
`ifdef DEMUX4_COLLECT_OVF_EN
                // Full and not draining: drop the word, flag the channel.
                ovf_d[sel] = 1'b1;
`else
                // Full and not draining: last write wins, slot stays full.
                slot_d[sel] = ch_arr[sel];
`endif
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the slots are reset too, not only the full flags, because
            // their contents are observable and must be 0 after reset.
            for (int i = 0; i < 4; i++) begin
                slot_q[i] <= '0;
            end
            full_q <= 4'b0000;
            ptr_q  <= 2'd0;
`ifdef DEMUX4_COLLECT_OVF_EN
            ovf_q  <= 4'b0000;
`endif
        end else begin
            slot_q <= slot_d;
            full_q <= full_d;
            ptr_q  <= ptr_d;
`ifdef DEMUX4_COLLECT_OVF_EN
            ovf_q  <= ovf_d;
`endif
        end
    end

endmodule

// File: doc/demux4_collect.md
# demux4_collect

Four-slot capture and drain stage placed directly downstream of the 4-way demultiplexer. Each cycle with `in_valid` high, the block latches the demux output selected by `sel` into that channel's holding slot. Full slots are drained round-robin through a single valid/ready output port, so a downstream consumer sees one tagged 4-bit word at a time.

## Interface
Parameters:
- `W`, 4: data width of each channel and of `out_data`.

Ports:
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `in_valid`  input  1  high when `sel` and `ch0..ch3` carry a word to capture.
- `sel`  input  2  channel steered by the demux this cycle.
- `ch0`, `ch1`, `ch2`, `ch3`  input  W each  demux outputs; only `ch[sel]` is sampled.
- `out_valid`  output  1  at least one slot is full.
- `out_ready`  input  1  consumer accepts `out_data` this cycle.
- `out_data`  output  W  contents of the granted slot.
- `out_chan`  output  2  index of the granted slot.
- `ovf`  output  4  sticky per-channel overflow flags.

## Operation
- State:
  - slots `slot[0..3]` (W bits each)
  - full flags `full[3:0]`
  - round-robin pointer `ptr[1:0]`
  - `ovf[3:0]`
- Grant is the first full slot found searching `ptr`, `ptr+1`, `ptr+2`, `ptr+3`, with indices wrapping modulo 4.
- `out_valid = |full`. `out_chan` is the grant index and `out_data = slot[grant]`. These outputs are combinational from registers only and have no input-to-output path.
- If `out_valid` is low, `out_data` and `out_chan` are 0.
- Drain: on an edge where `out_valid && out_ready` holds, `full[grant]` clears and `ptr` becomes `grant+1` (mod 4). `ptr` does not move without a drain.
- Capture: on an edge where `in_valid` is high, let `k = sel`. If `full[k]` is 0, or slot `k` is draining this same edge, then `slot[k]` gets `ch[k]` and `full[k]` is set.
- Slot `k` already full and not draining: behaviour depends on configuration (see below).
- Simultaneous capture and drain on the same slot: the consumer gets the old value, the new value is stored, and the slot stays full with no overflow.
- Captures and drains on different slots are independent within one cycle.

## Timing
- Reset, when `rst` is high at an edge:
  - `full = 0`, `ptr = 0`, `ovf = 0`, all slots 0.
  - Consequently `out_valid = 0`, `out_data = 0`, `out_chan = 0` from the following cycle on.
  - Reset overrides any capture or drain on the same edge, including mid-operation.
- Capture latency is 1 cycle. A word captured at edge N is visible on the outputs after edge N, and can be drained at edge N+1 at the earliest.
- Throughput is one drain per cycle when `out_ready` is held high.
- Handshake:
  - `out_data` and `out_chan` are stable while `out_valid && !out_ready`, unless a capture fills a slot that wins earlier in the search order. This is permitted because the grant is recomputed each cycle.
  - The consumer must sample only on a handshake edge.
- Wrap-around: with `ptr = 3` and a drain of slot 3, `ptr` becomes 0.

## Configuration
- `DEMUX4_COLLECT_OVF_EN` defined:
  - A capture into a full, non-draining slot is dropped, and `slot[k]` is unchanged.
  - `ovf[k]` sets and stays set until `rst`.
- `DEMUX4_COLLECT_OVF_EN` not defined:
  - A capture into a full slot overwrites it (last write wins), and `full[k]` remains 1.
  - `ovf` is constant 0.
- The port list is identical in both builds.

## Test plan
- Reset: assert `rst` for 2 edges with `in_valid=1`, `sel=2`, `ch2=4'hA` -> `out_valid=0`, `out_data=0`, `out_chan=0`, `ovf=0` after release, with nothing captured.
- Single path: `out_ready=0`; capture `sel=1`, `ch1=4'h5` -> next cycle `out_valid=1`, `out_chan=1`, `out_data=4'h5`. Raise `out_ready` for one edge -> `out_valid=0`, `ptr=2`.
- Round-robin: fill slots 0..3 with 1, 2, 3, 4 while `out_ready=0`, then hold `out_ready=1` -> drains in order `chan` 0, 1, 2, 3 with data 1, 2, 3, 4 on 4 consecutive edges. Refill slot 0 while slot 3 drains -> slot 0 is next, via wrap-around.
- Fairness: `ptr=2` and slots 0 and 3 full -> slot 3 is granted before slot 0.
- Same-slot capture and drain: slot 2 holds 4'h7, `out_ready=1`, and the same edge captures `sel=2`, `ch2=4'hC` -> consumer gets 7, slot 2 stays full with C, `ovf[2]=0`.
- Overflow: slot 1 holds 4'h3, `out_ready=0`, capture `sel=1`, `ch1=4'h9`.
  - With `DEMUX4_COLLECT_OVF_EN` -> `out_data` stays 3 and `ovf=4'b0010`, staying set until `rst`.
  - Without it -> `out_data` becomes 9 and `ovf=0`.
